// File: rtl/fir_tap_sequencer.sv
// FIR per-sample sequencer: holds the delay line and coefficients, walks one tap per cycle
// through the shared multiplier, and returns one saturated 32-bit result per accepted sample.
module fir_tap_sequencer #(
  parameter int N     = 16,
  parameter int TAPS  = 8,
  parameter int ACC_W = 36
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N-1:0]             in_sample,
  input  logic                     coef_we,
  input  logic [$clog2(TAPS)-1:0]  coef_addr,
  input  logic [N-1:0]             coef_data,
  output logic [N-1:0]             alu_a,
  output logic [N-1:0]             alu_b,
  output logic                     alu_sel,
  input  logic [31:0]              alu_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_y
);

  // state | meaning
  // IDLE  | waiting for a sample; coefficient writes accepted here only
  // MAC   | one tap per cycle through the shared ALU, accumulating products
  // HOLD  | result presented on out_y until the consumer takes it
  typedef enum logic [1:0] {IDLE, MAC, HOLD} state_t;

  localparam int AW = $clog2(TAPS);
  localparam logic [AW-1:0] LAST = AW'(TAPS - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-31){1'b0}}, {31{1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-31){1'b1}}, {31{1'b0}}};

  state_t                    state;
  logic        [N-1:0]       d    [TAPS];
  logic        [N-1:0]       coef [TAPS];
  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   acc_sum;
  logic        [AW-1:0]      idx;
  logic        [31:0]        y_sat;

  // ALU operands are combinational so alu_out settles within the same MAC cycle.
  always_comb begin
    in_ready = (state == IDLE);
    alu_sel  = (state == MAC);
    alu_a    = '0;
    alu_b    = '0;
    if (state == MAC) begin
      alu_a = d[idx];
      alu_b = coef[idx];
    end
  end

  always_comb begin
    acc_sum = acc + {{(ACC_W-32){alu_out[31]}}, alu_out};
    if (acc_sum > SAT_MAX)
      y_sat = 32'h7FFF_FFFF;
    else if (acc_sum < SAT_MIN)
      y_sat = 32'h8000_0000;
    else
      y_sat = acc_sum[31:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      idx       <= '0;
      out_valid <= 1'b0;
      out_y     <= '0;
      for (int k = 0; k < TAPS; k++) begin
        d[k]    <= '0;
        coef[k] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (coef_we)
            coef[coef_addr] <= coef_data;
          if (in_valid) begin
            for (int k = TAPS - 1; k >= 1; k--)
              d[k] <= d[k-1];
            d[0]  <= in_sample;
            acc   <= '0;
            idx   <= '0;
            state <= MAC;
          end
        end
        MAC: begin
          acc <= acc_sum;
          idx <= idx + 1'b1;
          if (idx == LAST) begin
            out_y     <= y_sat;
            out_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
